// File: rtl/switch_toggle_conditioner.sv
// rtl/switch_toggle_conditioner.sv - synchronise, debounce and tick-align DIP switch flicks
//
// Ports:
//   clk        : system clock, all state on rising edge
//   rst        : synchronous active-low reset
//   game_tick  : one-cycle strobe releasing captured flicks (tie high for per-cycle release)
//   DPSwitch   : raw asynchronous switch inputs
//   sw_stable  : debounced switch level
//   toggle     : one-cycle pulse per channel that flicked since the previous game_tick
//   toggle_any : OR of toggle, registered alongside it
module switch_toggle_conditioner #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             game_tick,
    input  logic [WIDTH-1:0] DPSwitch,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] toggle,
    output logic             toggle_any
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] r_toggle;
    logic             r_toggle_any;

    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_stable_nxt;
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];

    // Per-channel debounce: the count only advances while the synchronised
    // level disagrees with the accepted level; any agreement restarts it.
    always_comb begin
        w_edge       = '0;
        w_stable_nxt = r_stable;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_sync2[i] != r_stable[i]) begin
                if (r_cnt[i] == LP_CNT_LAST) begin
                    w_stable_nxt[i] = r_sync2[i];
                    w_edge[i]       = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_stable     <= '0;
            r_pending    <= '0;
            r_toggle     <= '0;
            r_toggle_any <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1  <= DPSwitch;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            if (game_tick) begin
                // An edge landing on the tick belongs to the next window.
                r_toggle     <= r_pending;
                r_toggle_any <= |r_pending;
                r_pending    <= w_edge;
            end else begin
                r_toggle     <= '0;
                r_toggle_any <= 1'b0;
                r_pending    <= r_pending | w_edge;
            end
        end
    end

    assign sw_stable  = r_stable;
    assign toggle     = r_toggle;
    assign toggle_any = r_toggle_any;

endmodule

// File: tb/tb_switch_toggle_conditioner.sv
// tb/tb_switch_toggle_conditioner.sv - directed self-checking bench for switch_toggle_conditioner
module tb_switch_toggle_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       game_tick;
    logic [7:0] DPSwitch;
    logic [7:0] sw_stable;
    logic [7:0] toggle;
    logic       toggle_any;

    int n_checks = 0;
    int n_errors = 0;

    switch_toggle_conditioner #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .game_tick  (game_tick),
        .DPSwitch   (DPSwitch),
        .sw_stable  (sw_stable),
        .toggle     (toggle),
        .toggle_any (toggle_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tick();
        game_tick = 1'b1;
        @(negedge clk);
        game_tick = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        game_tick = 1'b0;
        DPSwitch  = 8'hFF;

        // Reset held with all switches high
        for (int e = 0; e < 3; e++) begin
            @(negedge clk);
            check("rst_stable", sw_stable, 8'h00);
            check("rst_toggle", toggle, 8'h00);
            check("rst_any", toggle_any, 1'b0);
        end
        DPSwitch = 8'h00;
        rst      = 1'b1;
        step(6);
        check("idle_stable", sw_stable, 8'h00);
        check("idle_toggle", toggle, 8'h00);

        // Clean flick on bit 0, tick sampled on edge 10
        DPSwitch = 8'h01;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            if (e == 5)  check("flick_stable_e5", sw_stable, 8'h00);
            if (e == 6)  check("flick_stable_e6", sw_stable, 8'h01);
            if (e == 9)  check("flick_toggle_e9", toggle, 8'h00);
            if (e == 10) begin
                check("flick_toggle_e10", toggle, 8'h01);
                check("flick_any_e10", toggle_any, 1'b1);
            end
            if (e == 11) begin
                check("flick_toggle_e11", toggle, 8'h00);
                check("flick_any_e11", toggle_any, 1'b0);
            end
            game_tick = (e == 9);
        end
        game_tick = 1'b0;

        // Falling flick also produces a toggle
        DPSwitch = 8'h00;
        step(8);
        check("fall_stable", sw_stable, 8'h00);
        pulse_tick();
        check("fall_toggle", toggle, 8'h01);

        // Bounce on bit 3, period 4 cycles, ticks interleaved
        for (int c = 0; c < 20; c++) begin
            DPSwitch  = ((c / 2) % 2 == 0) ? 8'h08 : 8'h00;
            game_tick = (c % 5 == 4);
            @(negedge clk);
            check("bounce_stable", sw_stable, 8'h00);
            if (c % 5 == 4) check("bounce_toggle", toggle, 8'h00);
        end
        game_tick = 1'b0;
        DPSwitch  = 8'h00;
        step(6);
        pulse_tick();
        check("bounce_after_toggle", toggle, 8'h00);
        check("bounce_after_any", toggle_any, 1'b0);

        // Double flick on bit 5 in one window
        DPSwitch = 8'h20;
        step(8);
        check("dbl_stable_hi", sw_stable, 8'h20);
        DPSwitch = 8'h00;
        step(8);
        check("dbl_stable_lo", sw_stable, 8'h00);
        check("dbl_no_early", toggle, 8'h00);
        pulse_tick();
        check("dbl_toggle", toggle, 8'h20);
        check("dbl_any", toggle_any, 1'b1);
        step(1);
        check("dbl_toggle_clear", toggle, 8'h00);

        // Edge coincident with tick: bit 4 pending, bit 2 settles on the tick edge
        DPSwitch = 8'h10;
        step(8);
        check("coin_pend_stable", sw_stable, 8'h10);
        DPSwitch = 8'h14;
        for (int e = 1; e <= 6; e++) begin
            game_tick = (e == 6);
            @(negedge clk);
        end
        game_tick = 1'b0;
        check("coin_stable", sw_stable, 8'h14);
        check("coin_toggle1", toggle, 8'h10);
        step(2);
        check("coin_gap", toggle, 8'h00);
        pulse_tick();
        check("coin_toggle2", toggle, 8'h04);
        DPSwitch = 8'h00;
        step(8);
        pulse_tick();
        check("coin_release", toggle, 8'h14);

        // Reset mid-debounce: bit 0 pending, bit 7 count at 2
        DPSwitch = 8'h01;
        step(8);
        check("mid_pre_stable", sw_stable, 8'h01);
        DPSwitch = 8'h81;
        step(4);
        rst      = 1'b0;
        DPSwitch = 8'h00;
        @(negedge clk);
        check("mid_rst_stable", sw_stable, 8'h00);
        check("mid_rst_toggle", toggle, 8'h00);
        check("mid_rst_any", toggle_any, 1'b0);
        rst = 1'b1;
        pulse_tick();
        check("mid_tick1_toggle", toggle, 8'h00);
        step(8);
        check("mid_late_stable", sw_stable, 8'h00);
        pulse_tick();
        check("mid_tick2_toggle", toggle, 8'h00);
        check("mid_tick2_any", toggle_any, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
